// File: rtl/apb2axi_pkg.sv
// Shared types and constants for the APB-to-AXI bridge completion path:
// tag width, directory size, AXI response encodings and the completion record.
package apb2axi_pkg;

  localparam int TAG_W       = 3;
  localparam int DIR_ENTRIES = 1 << TAG_W;

  // Width of num_beats in the completion record; 9 bits covers 1..256 beats
  // and the saturated value 511.
  localparam int NUM_BEATS_W = 9;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_EXOKAY = 2'd1;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef struct packed {
    logic [TAG_W-1:0]       tag;
    logic [1:0]             resp;
    logic [NUM_BEATS_W-1:0] num_beats;
    logic                   error;
  } completion_entry_t;

endpackage

// File: rtl/apb2axi_cpl_fifo.sv
// Completion FIFO: up to two pushes and one pop per cycle. push1 is only
// meaningful together with push0 and is stored in the slot after data0.
// Storage is not reset; only pointers and occupancy are.
module apb2axi_cpl_fifo
  import apb2axi_pkg::*;
#(
  parameter int CQ_DEPTH = 4,
  localparam int AW = $clog2(CQ_DEPTH)
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              push0,
  input  completion_entry_t data0,
  input  logic              push1,
  input  completion_entry_t data1,
  input  logic              pop,
  output logic [AW:0]       count,
  output logic              empty,
  output completion_entry_t head
);

  localparam int CW = AW + 1;

  completion_entry_t mem [CQ_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     wr_ptr_nx;
  logic [1:0]        n_push;
  logic              pop_ok;

  assign wr_ptr_nx = wr_ptr + AW'(1);
  assign n_push    = {1'b0, push0} + {1'b0, push1};
  assign empty     = (count == '0);
  assign pop_ok    = pop && !empty;
  assign head      = mem[rd_ptr];

  // Write the pushed entries into consecutive slots.
  always_ff @(posedge pclk) begin
    if (push0) mem[wr_ptr] <= data0;
    if (push1) mem[wr_ptr_nx] <= data1;
  end

  // Pointers wrap naturally at CQ_DEPTH; occupancy nets pushes against pop.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(n_push);
      rd_ptr <= rd_ptr + AW'(pop_ok);
      count  <= count + CW'(n_push) - CW'(pop_ok);
    end
  end

endmodule

// File: rtl/apb2axi_cpl_queue.sv
// Completion queue: accumulates AXI read beats per tag, turns read-last beats
// and write responses into completion records, and hands them to the
// directory through a 2-push/1-pop FIFO.
// Optional feature macro: APB2AXI_CQ_BYPASS_EN -- when defined, a push into an
// empty queue is presented combinationally and skips storage if accepted.
module apb2axi_cpl_queue
  import apb2axi_pkg::*;
#(
  parameter int CQ_DEPTH = 4,
  parameter int BEAT_W   = 9
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic              rd_beat_vld,
  input  logic [TAG_W-1:0]  rd_beat_tag,
  input  logic [1:0]        rd_beat_resp,
  input  logic              rd_beat_last,
  input  logic              wr_resp_vld,
  input  logic [TAG_W-1:0]  wr_resp_tag,
  input  logic [1:0]        wr_resp_resp,
  output logic              in_rdy,
  output logic              cq_dir_cpl_vld,
  output completion_entry_t cq_dir_cpl_entry,
  input  logic              cq_dir_cpl_rdy
);

  localparam int AW = $clog2(CQ_DEPTH);
  localparam logic [BEAT_W-1:0] CNT_MAX   = '1;
  localparam logic [AW:0]       RDY_LIMIT = (AW + 1)'(CQ_DEPTH - 2);

  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [BEAT_W-1:0] cnt_sat_inc(input logic [BEAT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + BEAT_W'(1);
  endfunction

  // Clamp a beat count into the record's num_beats field.
  function automatic logic [NUM_BEATS_W-1:0] to_num_beats(input logic [BEAT_W-1:0] c);
    logic [31:0] w;
    w = 32'(c);
    if (w > (32'd1 << NUM_BEATS_W) - 32'd1) return '1;
    return NUM_BEATS_W'(w);
  endfunction

  logic [BEAT_W-1:0]      beat_cnt   [DIR_ENTRIES];
  logic [1:0]             worst_resp [DIR_ENTRIES];
  logic [DIR_ENTRIES-1:0] sat_err;

  logic              rd_acc_p0;
  logic              rd_push_p0;
  logic              wr_push_p0;
  logic [BEAT_W-1:0] cur_cnt_p0;
  logic [1:0]        cur_resp_p0;
  logic              cur_sat_p0;
  completion_entry_t rd_ent_p0;
  completion_entry_t wr_ent_p0;
  logic              first_vld_p0;
  completion_entry_t first_ent_p0;
  logic              second_vld_p0;

  logic              fifo_push0;
  completion_entry_t fifo_data0;
  logic              fifo_push1;
  logic              fifo_pop;
  logic [AW:0]       fifo_count;
  logic              fifo_empty;
  completion_entry_t fifo_head;

  // Acceptance depends only on registered occupancy (and reset), never on
  // this cycle's pop or valid inputs.
  assign in_rdy     = !preset && (fifo_count <= RDY_LIMIT);
  assign rd_acc_p0  = rd_beat_vld && in_rdy;
  assign rd_push_p0 = rd_acc_p0 && rd_beat_last;
  assign wr_push_p0 = wr_resp_vld && in_rdy;

  // ---- p0: build completion records from this cycle's accepted inputs ----
  // Merge the incoming beat into its tag's running count and worst response.
  always_comb begin
    cur_cnt_p0  = beat_cnt[rd_beat_tag];
    cur_resp_p0 = resp_max(worst_resp[rd_beat_tag], rd_beat_resp);
    cur_sat_p0  = sat_err[rd_beat_tag] || (cur_cnt_p0 == CNT_MAX);

    rd_ent_p0           = '0;
    rd_ent_p0.tag       = rd_beat_tag;
    rd_ent_p0.resp      = cur_resp_p0;
    rd_ent_p0.num_beats = to_num_beats(cnt_sat_inc(cur_cnt_p0));
    rd_ent_p0.error     = cur_resp_p0[1] || cur_sat_p0;

    wr_ent_p0           = '0;
    wr_ent_p0.tag       = wr_resp_tag;
    wr_ent_p0.resp      = wr_resp_resp;
    wr_ent_p0.num_beats = NUM_BEATS_W'(1);
    wr_ent_p0.error     = wr_resp_resp[1];

    // The read record goes first when both arrive together.
    first_vld_p0  = rd_push_p0 || wr_push_p0;
    first_ent_p0  = rd_push_p0 ? rd_ent_p0 : wr_ent_p0;
    second_vld_p0 = rd_push_p0 && wr_push_p0;
  end

  // Per-tag beat accounting; a last beat clears the tag for its next burst.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int i = 0; i < DIR_ENTRIES; i++) begin
        beat_cnt[i]   <= '0;
        worst_resp[i] <= '0;
      end
      sat_err <= '0;
    end else if (rd_acc_p0) begin
      if (rd_beat_last) begin
        beat_cnt[rd_beat_tag]   <= '0;
        worst_resp[rd_beat_tag] <= '0;
        sat_err[rd_beat_tag]    <= 1'b0;
      end else begin
        beat_cnt[rd_beat_tag]   <= cnt_sat_inc(cur_cnt_p0);
        worst_resp[rd_beat_tag] <= cur_resp_p0;
        sat_err[rd_beat_tag]    <= cur_sat_p0;
      end
    end
  end

  // ---- p1: FIFO storage and directory handshake ----
  // Route records into the FIFO and drive the directory-facing outputs.
  always_comb begin
    fifo_push0       = first_vld_p0;
    fifo_data0       = first_ent_p0;
    fifo_push1       = second_vld_p0;
    cq_dir_cpl_vld   = !fifo_empty;
    cq_dir_cpl_entry = fifo_empty ? '0 : fifo_head;
`ifdef APB2AXI_CQ_BYPASS_EN
    // Empty queue: show the first record directly; if taken now, store only
    // the second one.
    if (fifo_empty && first_vld_p0) begin
      cq_dir_cpl_vld   = 1'b1;
      cq_dir_cpl_entry = first_ent_p0;
      if (cq_dir_cpl_rdy) begin
        fifo_push0 = second_vld_p0;
        fifo_data0 = wr_ent_p0;
        fifo_push1 = 1'b0;
      end
    end
`endif
    fifo_pop = cq_dir_cpl_rdy && !fifo_empty;
  end

  apb2axi_cpl_fifo #(
    .CQ_DEPTH (CQ_DEPTH)
  ) u_fifo (
    .pclk   (pclk),
    .preset (preset),
    .push0  (fifo_push0),
    .data0  (fifo_data0),
    .push1  (fifo_push1),
    .data1  (wr_ent_p0),
    .pop    (fifo_pop),
    .count  (fifo_count),
    .empty  (fifo_empty),
    .head   (fifo_head)
  );

endmodule

// File: tb/tb_apb2axi_cpl_queue.sv
// Directed bench for apb2axi_cpl_queue (default build, CQ_DEPTH=4, BEAT_W=9).
// Inputs change and outputs are sampled on the falling edge of pclk.
module tb_apb2axi_cpl_queue;
  import apb2axi_pkg::*;

  logic              pclk;
  logic              preset;
  logic              rd_beat_vld;
  logic [TAG_W-1:0]  rd_beat_tag;
  logic [1:0]        rd_beat_resp;
  logic              rd_beat_last;
  logic              wr_resp_vld;
  logic [TAG_W-1:0]  wr_resp_tag;
  logic [1:0]        wr_resp_resp;
  logic              in_rdy;
  logic              cq_dir_cpl_vld;
  completion_entry_t cq_dir_cpl_entry;
  logic              cq_dir_cpl_rdy;

  int n_cmp = 0;
  int n_bad = 0;

  apb2axi_cpl_queue #(.CQ_DEPTH(4), .BEAT_W(9)) dut (
    .pclk             (pclk),
    .preset           (preset),
    .rd_beat_vld      (rd_beat_vld),
    .rd_beat_tag      (rd_beat_tag),
    .rd_beat_resp     (rd_beat_resp),
    .rd_beat_last     (rd_beat_last),
    .wr_resp_vld      (wr_resp_vld),
    .wr_resp_tag      (wr_resp_tag),
    .wr_resp_resp     (wr_resp_resp),
    .in_rdy           (in_rdy),
    .cq_dir_cpl_vld   (cq_dir_cpl_vld),
    .cq_dir_cpl_entry (cq_dir_cpl_entry),
    .cq_dir_cpl_rdy   (cq_dir_cpl_rdy)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_head(input string nm, input int t, input int r, input int nb, input int e);
    chk_eq({nm, "_vld"},  32'(cq_dir_cpl_vld), 32'd1);
    chk_eq({nm, "_tag"},  32'(cq_dir_cpl_entry.tag), 32'(t));
    chk_eq({nm, "_resp"}, 32'(cq_dir_cpl_entry.resp), 32'(r));
    chk_eq({nm, "_nb"},   32'(cq_dir_cpl_entry.num_beats), 32'(nb));
    chk_eq({nm, "_err"},  32'(cq_dir_cpl_entry.error), 32'(e));
  endtask

  task automatic rd_beat(input int t, input int r, input bit l);
    rd_beat_vld  = 1'b1;
    rd_beat_tag  = TAG_W'(t);
    rd_beat_resp = 2'(r);
    rd_beat_last = l;
    @(negedge pclk);
    rd_beat_vld  = 1'b0;
    rd_beat_last = 1'b0;
  endtask

  task automatic wr_resp(input int t, input int r);
    wr_resp_vld  = 1'b1;
    wr_resp_tag  = TAG_W'(t);
    wr_resp_resp = 2'(r);
    @(negedge pclk);
    wr_resp_vld  = 1'b0;
  endtask

  task automatic pop_one();
    cq_dir_cpl_rdy = 1'b1;
    @(negedge pclk);
    cq_dir_cpl_rdy = 1'b0;
  endtask

  initial begin
    preset = 1'b1;
    rd_beat_vld = 1'b0; rd_beat_tag = '0; rd_beat_resp = '0; rd_beat_last = 1'b0;
    wr_resp_vld = 1'b0; wr_resp_tag = '0; wr_resp_resp = '0;
    cq_dir_cpl_rdy = 1'b0;
    @(negedge pclk);
    @(negedge pclk);

    // Reset state
    chk_eq("rst_vld",   32'(cq_dir_cpl_vld), 32'd0);
    chk_eq("rst_entry", 32'(cq_dir_cpl_entry), 32'd0);
    chk_eq("rst_in_rdy", 32'(in_rdy), 32'd0);
    preset = 1'b0;
    #1;
    chk_eq("post_rst_in_rdy", 32'(in_rdy), 32'd1);
    @(negedge pclk);

    // Tag 3: four OKAY beats, last on the fourth
    for (int i = 0; i < 3; i++) rd_beat(3, 0, 1'b0);
    chk_eq("t3_no_early_cpl", 32'(cq_dir_cpl_vld), 32'd0);
    rd_beat(3, 0, 1'b1);
    check_head("t3", 3, 0, 4, 0);
    pop_one();
    chk_eq("t3_drained", 32'(cq_dir_cpl_vld), 32'd0);

    // Tag 1: OKAY, SLVERR, OKAY(last) -> worst SLVERR
    rd_beat(1, 0, 1'b0);
    rd_beat(1, 2, 1'b0);
    rd_beat(1, 0, 1'b1);
    check_head("t1", 1, 2, 3, 1);
    pop_one();

    // Read-last tag 2 and write tag 5 in the same cycle
    wr_resp_vld = 1'b1; wr_resp_tag = 3'd5; wr_resp_resp = 2'd0;
    rd_beat(2, 0, 1'b1);
    wr_resp_vld = 1'b0;
    chk_eq("dual_in_rdy_occ2", 32'(in_rdy), 32'd1);
    check_head("dual_rd", 2, 0, 1, 0);
    pop_one();
    check_head("dual_wr", 5, 0, 1, 0);
    pop_one();
    chk_eq("dual_drained", 32'(cq_dir_cpl_vld), 32'd0);

    // Back-pressure: three writes with rdy low, then drain in order
    wr_resp(0, 0);
    chk_eq("bp_in_rdy_occ1", 32'(in_rdy), 32'd1);
    wr_resp(1, 1);
    chk_eq("bp_in_rdy_occ2", 32'(in_rdy), 32'd1);
    wr_resp(2, 3);
    chk_eq("bp_in_rdy_occ3", 32'(in_rdy), 32'd0);
    rd_beat(6, 0, 1'b1);   // refused while in_rdy is low
    check_head("bp_h0", 0, 0, 1, 0);
    cq_dir_cpl_rdy = 1'b1;
    @(negedge pclk);
    check_head("bp_h1", 1, 1, 1, 0);
    @(negedge pclk);
    check_head("bp_h2", 2, 3, 1, 1);
    @(negedge pclk);
    chk_eq("bp_drained", 32'(cq_dir_cpl_vld), 32'd0);
    cq_dir_cpl_rdy = 1'b0;

    // Refused beat on tag 6 left no trace
    rd_beat(6, 0, 1'b1);
    check_head("t6_single", 6, 0, 1, 0);
    pop_one();

    // Interleaved tags 0 (2 beats) and 7 (5 beats, one EXOKAY)
    rd_beat(7, 0, 1'b0);
    rd_beat(0, 0, 1'b0);
    rd_beat(7, 1, 1'b0);
    rd_beat(0, 0, 1'b1);
    check_head("il_t0", 0, 0, 2, 0);
    rd_beat(7, 0, 1'b0);
    rd_beat(7, 0, 1'b0);
    rd_beat(7, 0, 1'b1);
    check_head("il_t0_held", 0, 0, 2, 0);
    pop_one();
    check_head("il_t7", 7, 1, 5, 0);
    pop_one();

    // Counter saturation: 512 non-last beats then last on tag 6
    for (int i = 0; i < 512; i++) rd_beat(6, 0, 1'b0);
    rd_beat(6, 0, 1'b1);
    check_head("sat", 6, 0, 511, 1);
    pop_one();
    rd_beat(6, 0, 1'b1);
    check_head("sat_cleared", 6, 0, 1, 0);
    pop_one();

    // Reset mid-burst discards partial count and queued completion
    rd_beat(4, 0, 1'b0);
    rd_beat(4, 0, 1'b0);
    wr_resp(3, 0);
    chk_eq("pre_rst_vld", 32'(cq_dir_cpl_vld), 32'd1);
    preset = 1'b1;
    #1;
    chk_eq("mid_rst_vld", 32'(cq_dir_cpl_vld), 32'd0);
    chk_eq("mid_rst_entry", 32'(cq_dir_cpl_entry), 32'd0);
    chk_eq("mid_rst_in_rdy", 32'(in_rdy), 32'd0);
    @(negedge pclk);
    preset = 1'b0;
    #1;
    chk_eq("mid_post_rst_in_rdy", 32'(in_rdy), 32'd1);
    chk_eq("mid_post_rst_vld", 32'(cq_dir_cpl_vld), 32'd0);
    rd_beat(4, 0, 1'b1);
    check_head("t4_after_rst", 4, 0, 1, 0);
    pop_one();
    chk_eq("final_empty", 32'(cq_dir_cpl_vld), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
